// File: rtl/uart_sys_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_sys_pkg
// Description : Command codes and sequencer state encoding for uart_cmd_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_sys_pkg;

  localparam logic [7:0] CMD_WR   = 8'hAA;
  localparam logic [7:0] CMD_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU  = 8'hCC;
  localparam logic [7:0] CMD_ALUN = 8'hDD;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    OP_A     = 4'd5,
    OP_B     = 4'd6,
    FUN      = 4'd7,
    ALU_WAIT = 4'd8,
    TX_LO    = 4'd9,
    TX_HI    = 4'd10,
    TX_RD    = 4'd11
  } state_t;

endpackage : uart_sys_pkg
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_ctrl
// Description : Decodes UART command frames into regfile/ALU operations and
//               pushes response bytes to the TX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl
  import uart_sys_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter int ALU_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  input  logic                  rf_rd_valid,
  input  logic [ALU_WIDTH-1:0]  alu_out,
  input  logic                  alu_out_valid,
  input  logic                  tx_full,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  alu_en,
  output logic [FUN_WIDTH-1:0]  alu_fun,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid
);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_rd_byte;
  logic [FUN_WIDTH-1:0]  r_fun;
  logic [ALU_WIDTH-1:0]  r_result;
  logic                  w_take;
  logic                  w_tx_ok;

  // Strobes are suppressed while rst is high so an aborted frame has no side effects.
  assign w_take  = rx_valid && !rst;
  assign w_tx_ok = !tx_full && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == DATA_WIDTH'(CMD_WR)) begin
            w_next = WR_ADDR;
          end else if (rx_data == DATA_WIDTH'(CMD_RD)) begin
            w_next = RD_ADDR;
          end else if (rx_data == DATA_WIDTH'(CMD_ALU)) begin
            w_next = OP_A;
          end else if (rx_data == DATA_WIDTH'(CMD_ALUN)) begin
            w_next = FUN;
          end
        end
      end
      WR_ADDR:  if (rx_valid)      w_next = WR_DATA;
      WR_DATA:  if (rx_valid)      w_next = IDLE;
      RD_ADDR:  if (rx_valid)      w_next = RD_WAIT;
      RD_WAIT:  if (rf_rd_valid)   w_next = TX_RD;
      OP_A:     if (rx_valid)      w_next = OP_B;
      OP_B:     if (rx_valid)      w_next = FUN;
      FUN:      if (rx_valid)      w_next = ALU_WAIT;
      ALU_WAIT: if (alu_out_valid) w_next = TX_LO;
      TX_LO:    if (!tx_full)      w_next = TX_HI;
      TX_HI:    if (!tx_full)      w_next = IDLE;
      TX_RD:    if (!tx_full)      w_next = IDLE;
      default:                     w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_rd_byte <= '0;
      r_fun     <= '0;
      r_result  <= '0;
    end else begin
      if ((r_state == WR_ADDR || r_state == RD_ADDR) && rx_valid) begin
        r_addr <= rx_data[ADDR_WIDTH-1:0];
      end
      if (r_state == RD_WAIT && rf_rd_valid) begin
        r_rd_byte <= rf_rd_data;
      end
      if (r_state == FUN && rx_valid) begin
        r_fun <= rx_data[FUN_WIDTH-1:0];
      end
      if (r_state == ALU_WAIT && alu_out_valid) begin
        r_result <= alu_out;
      end
    end
  end

  // alu_fun follows the registered function so it stays stable through ALU_WAIT.
  always_comb begin
    rf_wr_en   = 1'b0;
    rf_rd_en   = 1'b0;
    rf_addr    = '0;
    rf_wr_data = '0;
    alu_en     = 1'b0;
    alu_fun    = r_fun;
    tx_data    = '0;
    tx_valid   = 1'b0;
    case (r_state)
      WR_DATA: begin
        if (w_take) begin
          rf_wr_en   = 1'b1;
          rf_addr    = r_addr;
          rf_wr_data = rx_data;
        end
      end
      RD_ADDR: begin
        if (w_take) begin
          rf_rd_en = 1'b1;
          rf_addr  = rx_data[ADDR_WIDTH-1:0];
        end
      end
      OP_A: begin
        if (w_take) begin
          rf_wr_en   = 1'b1;
          rf_addr    = ADDR_WIDTH'(0);
          rf_wr_data = rx_data;
        end
      end
      OP_B: begin
        if (w_take) begin
          rf_wr_en   = 1'b1;
          rf_addr    = ADDR_WIDTH'(1);
          rf_wr_data = rx_data;
        end
      end
      FUN: begin
        if (w_take) begin
          alu_en  = 1'b1;
          alu_fun = rx_data[FUN_WIDTH-1:0];
        end
      end
      TX_LO: begin
        tx_data  = r_result[DATA_WIDTH-1:0];
        tx_valid = w_tx_ok;
      end
      TX_HI: begin
        tx_data  = r_result[ALU_WIDTH-1:DATA_WIDTH];
        tx_valid = w_tx_ok;
      end
      TX_RD: begin
        tx_data  = r_rd_byte;
        tx_valid = w_tx_ok;
      end
      default: begin
      end
    endcase
  end

endmodule : uart_cmd_ctrl
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_ctrl
// Description : Directed vector bench for uart_cmd_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  rf_rd_data;
  logic        rf_rd_valid;
  logic [15:0] alu_out;
  logic        alu_out_valid;
  logic        tx_full;
  logic        rf_wr_en;
  logic        rf_rd_en;
  logic [3:0]  rf_addr;
  logic [7:0]  rf_wr_data;
  logic        alu_en;
  logic [3:0]  alu_fun;
  logic [7:0]  tx_data;
  logic        tx_valid;

  uart_cmd_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rf_rd_data    (rf_rd_data),
    .rf_rd_valid   (rf_rd_valid),
    .alu_out       (alu_out),
    .alu_out_valid (alu_out_valid),
    .tx_full       (tx_full),
    .rf_wr_en      (rf_wr_en),
    .rf_rd_en      (rf_rd_en),
    .rf_addr       (rf_addr),
    .rf_wr_data    (rf_wr_data),
    .alu_en        (alu_en),
    .alu_fun       (alu_fun),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event logs written only by the monitor process.
  logic [11:0] q_wr[$];
  logic [3:0]  q_rd[$];
  logic [3:0]  q_alu[$];
  logic [7:0]  q_tx[$];
  int          n_overlap = 0;
  int          n_tx_full = 0;
  logic        rd_pend   = 1'b0;
  logic        alu_pend  = 1'b0;
  int          mon_n;

  // Monitor on negedge; regfile/ALU responders answer one cycle after the strobe.
  initial begin
    rf_rd_valid   = 1'b0;
    alu_out_valid = 1'b0;
    forever begin
      @(negedge clk);
      mon_n = int'(rf_wr_en) + int'(rf_rd_en) + int'(alu_en) + int'(tx_valid);
      if (mon_n > 1) n_overlap++;
      if (rf_wr_en) q_wr.push_back({rf_addr, rf_wr_data});
      if (rf_rd_en) begin
        q_rd.push_back(rf_addr);
        rd_pend = 1'b1;
      end
      if (alu_en) begin
        q_alu.push_back(alu_fun);
        alu_pend = 1'b1;
      end
      if (tx_valid) begin
        if (tx_full) n_tx_full++;
        q_tx.push_back(tx_data);
      end
      @(posedge clk);
      #1;
      rf_rd_valid   = rd_pend;
      alu_out_valid = alu_pend;
      rd_pend       = 1'b0;
      alu_pend      = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  typedef struct {
    int          nb;
    logic [31:0] bytes;   // first byte in [31:24]
    logic [7:0]  rd;
    logic [15:0] alu;
    int          nwr;
    logic [23:0] wr;      // {addr,data} pairs, first in [23:12]
    int          nrd;
    logic [3:0]  rda;
    int          nalu;
    logic [3:0]  fun;
    int          ntx;
    logic [15:0] tx;      // first byte in [15:8]
  } vec_t;

  localparam int NV = 7;
  vec_t vt[NV];
  int   b_wr, b_rd, b_alu, b_tx;

  task automatic mark();
    b_wr  = q_wr.size();
    b_rd  = q_rd.size();
    b_alu = q_alu.size();
    b_tx  = q_tx.size();
  endtask

  initial begin
    rst        = 1'b1;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    rf_rd_data = 8'h00;
    alu_out    = 16'h0000;
    tx_full    = 1'b0;

    vt[0] = '{3, 32'hAA053C00, 8'h00, 16'h0000, 1, 24'h53C000, 0, 4'h0, 0, 4'h0, 0, 16'h0000};
    vt[1] = '{2, 32'hBB050000, 8'h3C, 16'h0000, 0, 24'h000000, 1, 4'h5, 0, 4'h0, 1, 16'h3C00};
    vt[2] = '{4, 32'hCC070300, 8'h00, 16'h000A, 2, 24'h007103, 0, 4'h0, 1, 4'h0, 2, 16'h0A00};
    vt[3] = '{4, 32'h55AA01FF, 8'h00, 16'h0000, 1, 24'h1FF000, 0, 4'h0, 0, 4'h0, 0, 16'h0000};
    vt[4] = '{2, 32'hBBF90000, 8'hA5, 16'h0000, 0, 24'h000000, 1, 4'h9, 0, 4'h0, 1, 16'hA500};
    vt[5] = '{2, 32'hDD0B0000, 8'h00, 16'hBEEF, 0, 24'h000000, 0, 4'h0, 1, 4'hB, 2, 16'hEFBE};
    vt[6] = '{4, 32'hCC1234F7, 8'h00, 16'h1234, 2, 24'h012134, 0, 4'h0, 1, 4'h7, 2, 16'h3412};

    repeat (3) tick();
    @(negedge clk);
    chk("reset_outputs",
        {8'h0, rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, tx_data, tx_valid},
        32'h0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      mark();
      rf_rd_data = vt[i].rd;
      alu_out    = vt[i].alu;
      for (int k = 0; k < vt[i].nb; k++) send_byte(vt[i].bytes[31-8*k -: 8]);
      repeat (12) tick();
      chk($sformatf("v%0d_wr_count", i), 32'(q_wr.size() - b_wr), 32'(vt[i].nwr));
      for (int k = 0; k < vt[i].nwr; k++)
        if (q_wr.size() > b_wr + k)
          chk($sformatf("v%0d_wr%0d", i, k), 32'(q_wr[b_wr+k]), 32'(vt[i].wr[23-12*k -: 12]));
      chk($sformatf("v%0d_rd_count", i), 32'(q_rd.size() - b_rd), 32'(vt[i].nrd));
      if (vt[i].nrd > 0 && q_rd.size() > b_rd)
        chk($sformatf("v%0d_rd_addr", i), 32'(q_rd[b_rd]), 32'(vt[i].rda));
      chk($sformatf("v%0d_alu_count", i), 32'(q_alu.size() - b_alu), 32'(vt[i].nalu));
      if (vt[i].nalu > 0 && q_alu.size() > b_alu)
        chk($sformatf("v%0d_alu_fun", i), 32'(q_alu[b_alu]), 32'(vt[i].fun));
      chk($sformatf("v%0d_tx_count", i), 32'(q_tx.size() - b_tx), 32'(vt[i].ntx));
      for (int k = 0; k < vt[i].ntx; k++)
        if (q_tx.size() > b_tx + k)
          chk($sformatf("v%0d_tx%0d", i, k), 32'(q_tx[b_tx+k]), 32'(vt[i].tx[15-8*k -: 8]));
    end

    // DD,02 with TX FIFO full: bytes held, a stray rx byte dropped, then drained in order.
    mark();
    alu_out = 16'h5A3C;
    tx_full = 1'b1;
    send_byte(8'hDD);
    send_byte(8'h02);
    repeat (4) tick();
    send_byte(8'hAA);
    repeat (5) tick();
    chk("full_alu_fun", (q_alu.size() > b_alu) ? 32'(q_alu[b_alu]) : 32'hFFFF, 32'h2);
    chk("full_no_tx", 32'(q_tx.size() - b_tx), 32'd0);
    tx_full = 1'b0;
    repeat (6) tick();
    chk("full_tx_count", 32'(q_tx.size() - b_tx), 32'd2);
    chk("full_tx_lo", (q_tx.size() > b_tx) ? 32'(q_tx[b_tx]) : 32'hFFFF, 32'h3C);
    chk("full_tx_hi", (q_tx.size() > b_tx + 1) ? 32'(q_tx[b_tx+1]) : 32'hFFFF, 32'h5A);
    mark();
    send_byte(8'hAA);
    send_byte(8'h04);
    send_byte(8'h11);
    repeat (3) tick();
    chk("after_full_wr_count", 32'(q_wr.size() - b_wr), 32'd1);
    chk("after_full_wr", (q_wr.size() > b_wr) ? 32'(q_wr[b_wr]) : 32'hFFFF, 32'h411);

    // Partial frame with idle gaps between bytes.
    mark();
    send_byte(8'hAA);
    repeat (5) tick();
    send_byte(8'h03);
    repeat (5) tick();
    send_byte(8'h77);
    repeat (3) tick();
    chk("gap_wr_count", 32'(q_wr.size() - b_wr), 32'd1);
    chk("gap_wr", (q_wr.size() > b_wr) ? 32'(q_wr[b_wr]) : 32'hFFFF, 32'h377);

    // Reset mid-frame after CC,07: byte arriving during reset must not write.
    mark();
    alu_out = 16'h0101;
    send_byte(8'hCC);
    send_byte(8'h07);
    rst      = 1'b1;
    rx_data  = 8'h03;
    rx_valid = 1'b1;
    tick();
    tick();
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (8) tick();
    chk("rst_wr_count", 32'(q_wr.size() - b_wr), 32'd1);
    chk("rst_alu_count", 32'(q_alu.size() - b_alu), 32'd0);
    chk("rst_tx_count", 32'(q_tx.size() - b_tx), 32'd0);
    mark();
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h44);
    repeat (3) tick();
    chk("post_rst_wr_count", 32'(q_wr.size() - b_wr), 32'd1);
    chk("post_rst_wr", (q_wr.size() > b_wr) ? 32'(q_wr[b_wr]) : 32'hFFFF, 32'h244);

    chk("strobe_overlap", 32'(n_overlap), 32'd0);
    chk("tx_while_full", 32'(n_tx_full), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_cmd_ctrl
`default_nettype wire
